// File: rtl/traffic_phase_ctrl_pkg.sv
// Shared phase codes, light constants and duration helpers
// for the traffic phase sequencer and the display decoder.
package traffic_phase_ctrl_pkg;

  typedef enum logic [2:0] {
    PH_MG    = 3'd0,
    PH_MY    = 3'd1,
    PH_AR1   = 3'd2,
    PH_SG    = 3'd3,
    PH_SY    = 3'd4,
    PH_AR2   = 3'd5,
    PH_NIGHT = 3'd6
  } phase_e;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  function automatic bit dur_ok(int d);
    return (d >= 1) && (d <= 255);
  endfunction

  function automatic phase_e next_phase(phase_e p);
    phase_e n;
    n = PH_MG;
    unique case (p)
      PH_MG:   n = PH_MY;
      PH_MY:   n = PH_AR1;
      PH_AR1:  n = PH_SG;
      PH_SG:   n = PH_SY;
      PH_SY:   n = PH_AR2;
      default: n = PH_MG;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] main_of(phase_e p);
    logic [2:0] l;
    l = RED;
    unique case (p)
      PH_MG:   l = GRN;
      PH_MY:   l = YEL;
      default: l = RED;
    endcase
    return l;
  endfunction

  function automatic logic [2:0] side_of(phase_e p);
    logic [2:0] l;
    l = RED;
    unique case (p)
      PH_SG:   l = GRN;
      PH_SY:   l = YEL;
      default: l = RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_sec_tick.sv
// sec_tick_edge: rising-edge detector on the divider output.
// Ports: Fin clock, rst sync reset, sec_clk in, tick 1-cycle pulse out.
module sec_tick_edge (
  input  logic Fin,
  input  logic rst,
  input  logic sec_clk,
  output logic tick
);

  logic sec_clk_q;

  always_ff @(posedge Fin) begin
    if (rst) sec_clk_q <= 1'b0;
    else     sec_clk_q <= sec_clk;
  end

  assign tick = sec_clk & ~sec_clk_q;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: main/side phase sequencer with seconds countdown,
// night flashing mode and optional side-road request hold (PED_REQ_EN).
// Ports: Fin, rst (sync, high), sec_clk, night, side_req (PED_REQ_EN),
//        main_ryg/side_ryg {R,Y,G}, countdown[7:0], phase[2:0].
module traffic_phase_ctrl
  import traffic_phase_ctrl_pkg::*;
#(
  parameter int T_MG = 30,
  parameter int T_MY = 3,
  parameter int T_SG = 20,
  parameter int T_SY = 3,
  parameter int T_AR = 1
) (
  input  logic       Fin,
  input  logic       rst,
  input  logic       sec_clk,
  input  logic       night,
`ifdef PED_REQ_EN
  input  logic       side_req,
`endif
  output logic [2:0] main_ryg,
  output logic [2:0] side_ryg,
  output logic [7:0] countdown,
  output logic [2:0] phase
);

  if (!dur_ok(T_MG) || !dur_ok(T_MY) || !dur_ok(T_SG) ||
      !dur_ok(T_SY) || !dur_ok(T_AR)) begin : g_bad_dur
    $error("traffic_phase_ctrl: durations must be 1..255");
  end

  localparam logic [7:0] D_MG = 8'(T_MG);
  localparam logic [7:0] D_MY = 8'(T_MY);
  localparam logic [7:0] D_SG = 8'(T_SG);
  localparam logic [7:0] D_SY = 8'(T_SY);
  localparam logic [7:0] D_AR = 8'(T_AR);

  function automatic logic [7:0] dur_of(phase_e p);
    logic [7:0] d;
    d = D_AR;
    unique case (p)
      PH_MG:   d = D_MG;
      PH_MY:   d = D_MY;
      PH_SG:   d = D_SG;
      PH_SY:   d = D_SY;
      default: d = D_AR;
    endcase
    return d;
  endfunction

  logic       tick;
  logic       hold;
  phase_e     ph_q, ph_d, ph_n;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] main_q, main_d;
  logic [2:0] side_q, side_d;

  sec_tick_edge u_tick (
    .Fin     (Fin),
    .rst     (rst),
    .sec_clk (sec_clk),
    .tick    (tick)
  );

`ifdef PED_REQ_EN
  logic req_q, req_d;
  // Main green parks at 1 until a side request is pending.
  assign hold = (ph_q == PH_MG) && !req_q;
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    ph_d   = ph_q;
    cnt_d  = cnt_q;
    main_d = main_q;
    side_d = side_q;
    ph_n   = next_phase(ph_q);
    // Night has priority over any tick in the same cycle.
    if (night) begin
      if (ph_q != PH_NIGHT) begin
        ph_d   = PH_NIGHT;
        cnt_d  = 8'd0;
        main_d = YEL;
        side_d = YEL;
      end else if (tick) begin
        main_d = (main_q == YEL) ? OFF : YEL;
        side_d = (main_q == YEL) ? OFF : YEL;
      end
    end else if (ph_q == PH_NIGHT) begin
      // Leave night through all-red, never directly to green.
      ph_d   = PH_AR2;
      cnt_d  = D_AR;
      main_d = RED;
      side_d = RED;
    end else if (tick) begin
      if (cnt_q != 8'd1) begin
        cnt_d = cnt_q - 8'd1;
      end else if (!hold) begin
        ph_d   = ph_n;
        cnt_d  = dur_of(ph_n);
        main_d = main_of(ph_n);
        side_d = side_of(ph_n);
      end
    end
  end

`ifdef PED_REQ_EN
  // Entering SG consumes the request, even one arriving that cycle.
  always_comb begin
    req_d = req_q | side_req;
    if (ph_d == PH_SG && ph_q != PH_SG) req_d = 1'b0;
  end
`endif

  always_ff @(posedge Fin) begin
    if (rst) begin
      ph_q   <= PH_MG;
      cnt_q  <= D_MG;
      main_q <= GRN;
      side_q <= RED;
`ifdef PED_REQ_EN
      req_q  <= 1'b0;
`endif
    end else begin
      ph_q   <= ph_d;
      cnt_q  <= cnt_d;
      main_q <= main_d;
      side_q <= side_d;
`ifdef PED_REQ_EN
      req_q  <= req_d;
`endif
    end
  end

  assign main_ryg  = main_q;
  assign side_ryg  = side_q;
  assign countdown = cnt_q;
  assign phase     = ph_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Testbench for traffic_phase_ctrl: random tick spacing and actions
// checked against a sequence-table model of the phase cycle.
module tb_traffic_phase_ctrl;

  logic       Fin = 1'b0;
  logic       rst = 1'b1;
  logic       sec_clk = 1'b0;
  logic       night = 1'b0;
`ifdef PED_REQ_EN
  logic       side_req = 1'b0;
`endif
  logic [2:0] main_ryg, side_ryg, phase;
  logic [7:0] countdown;

  int total = 0;
  int bad = 0;

  always #5 Fin = ~Fin;

  traffic_phase_ctrl #(
    .T_MG(3), .T_MY(2), .T_SG(2), .T_SY(1), .T_AR(1)
  ) dut (
    .Fin       (Fin),
    .rst       (rst),
    .sec_clk   (sec_clk),
    .night     (night),
`ifdef PED_REQ_EN
    .side_req  (side_req),
`endif
    .main_ryg  (main_ryg),
    .side_ryg  (side_ryg),
    .countdown (countdown),
    .phase     (phase)
  );

  // Model: position in the six-step cycle plus seconds left.
  int         dur_t [6] = '{3, 2, 1, 2, 1, 1};
  logic [2:0] mn_t  [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] sd_t  [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
  int m_idx, m_rem;
  bit m_night, m_flash, m_latch;

  wire [16:0] obs = {phase, countdown, main_ryg, side_ryg};

  function automatic logic [16:0] expv();
    logic [2:0] fl;
    fl = m_flash ? 3'b010 : 3'b000;
    if (m_night) return {3'd6, 8'd0, fl, fl};
    return {3'(m_idx), 8'(m_rem), mn_t[m_idx], sd_t[m_idx]};
  endfunction

  function automatic void m_reset();
    m_idx = 0; m_rem = 3; m_night = 0; m_flash = 0; m_latch = 0;
  endfunction

  function automatic void m_tick();
    if (m_night) begin
      m_flash = !m_flash;
      return;
    end
    if (m_rem > 1) begin
      m_rem--;
      return;
    end
`ifdef PED_REQ_EN
    if (m_idx == 0 && !m_latch) return;
`endif
    m_idx = (m_idx + 1) % 6;
    m_rem = dur_t[m_idx];
    if (m_idx == 3) m_latch = 0;
  endfunction

  function automatic void m_night_on();
    if (!m_night) begin
      m_night = 1; m_flash = 1;
    end
  endfunction

  function automatic void m_night_off();
    if (m_night) begin
      m_night = 0; m_idx = 5; m_rem = 1;
    end
  endfunction

  task automatic tick_rise();
    sec_clk = 1'b1;
    m_tick();
    @(negedge Fin);
  endtask

  task automatic tick_fall();
    repeat ($urandom_range(1, 3)) @(negedge Fin);
    sec_clk = 1'b0;
    repeat ($urandom_range(3, 5)) @(negedge Fin);
  endtask

  task automatic do_tick();
    tick_rise();
    tick_fall();
  endtask

`ifdef PED_REQ_EN
  task automatic req_pulse();
    side_req = 1'b1;
    m_latch = 1;
    @(negedge Fin);
    side_req = 1'b0;
  endtask
`endif

  task automatic go_to(int idx, int rem, bit auto_req);
    for (int k = 0; k < 40; k++) begin
      if (m_idx == idx && m_rem == rem && !m_night) break;
`ifdef PED_REQ_EN
      if (auto_req && m_idx == 0 && m_rem == 1 && !m_latch) req_pulse();
`endif
      do_tick();
    end
    total++;
    if (!(m_idx == idx && m_rem == rem)) begin
      $display("FAIL go_to: model at %0d/%0d want %0d/%0d", m_idx, m_rem, idx, rem);
      bad++;
    end
    if (auto_req) ;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_reset();
    repeat (3) @(negedge Fin);
    total++;
    if (obs !== expv()) begin
      $display("FAIL reset_held: got %h want %h", obs, expv()); bad++;
    end
    rst = 1'b0;
    repeat (2) @(negedge Fin);
    total++;
    if (obs !== expv()) begin
      $display("FAIL reset_release: got %h want %h", obs, expv()); bad++;
    end
  endtask

  task automatic test_cycle();
    for (int i = 0; i < 20; i++) begin
      tick_rise();
      total++;
      if (obs !== expv()) begin
        $display("FAIL cycle[%0d]: got %h want %h", i, obs, expv()); bad++;
      end
      tick_fall();
    end
  endtask

  task automatic test_hold();
    logic [16:0] snap;
    go_to(3, 2, 1'b1);
    snap = expv();
    for (int i = 0; i < 5; i++) begin
      repeat (10) @(negedge Fin);
      total++;
      if (obs !== snap) begin
        $display("FAIL hold[%0d]: got %h want %h", i, obs, snap); bad++;
      end
    end
    do_tick();
    total++;
    if (obs !== expv() || countdown !== 8'd1) begin
      $display("FAIL hold_step: got %h want %h", obs, expv()); bad++;
    end
  endtask

  task automatic test_night();
    go_to(1, 2, 1'b1);
    night = 1'b1;
    m_night_on();
    @(negedge Fin);
    total++;
    if (obs !== expv()) begin
      $display("FAIL night_entry: got %h want %h", obs, expv()); bad++;
    end
    for (int i = 0; i < 3; i++) begin
      do_tick();
      total++;
      if (obs !== expv()) begin
        $display("FAIL night_flash[%0d]: got %h want %h", i, obs, expv()); bad++;
      end
    end
    night = 1'b0;
    m_night_off();
    @(negedge Fin);
    total++;
    if (obs !== expv()) begin
      $display("FAIL night_exit: got %h want %h", obs, expv()); bad++;
    end
    do_tick();
    total++;
    if (obs !== expv()) begin
      $display("FAIL night_to_mg: got %h want %h", obs, expv()); bad++;
    end
  endtask

  task automatic test_night_tick();
    go_to(0, 2, 1'b1);
    night = 1'b1;
    sec_clk = 1'b1;
    m_night_on();
    @(negedge Fin);
    total++;
    if (obs !== expv()) begin
      $display("FAIL night_tick: got %h want %h", obs, expv()); bad++;
    end
    tick_fall();
    total++;
    if (obs !== expv()) begin
      $display("FAIL night_tick_settle: got %h want %h", obs, expv()); bad++;
    end
    night = 1'b0;
    m_night_off();
    @(negedge Fin);
    do_tick();
    total++;
    if (obs !== expv()) begin
      $display("FAIL night_tick_exit: got %h want %h", obs, expv()); bad++;
    end
  endtask

  task automatic test_reset_mid();
    go_to(3, 1, 1'b1);
    rst = 1'b1;
    @(negedge Fin);
    rst = 1'b0;
    m_reset();
    total++;
    if (obs !== expv()) begin
      $display("FAIL reset_mid_sg: got %h want %h", obs, expv()); bad++;
    end
    night = 1'b1;
    m_night_on();
    @(negedge Fin);
    rst = 1'b1;
    m_reset();
    @(negedge Fin);
    total++;
    if (obs !== expv()) begin
      $display("FAIL reset_in_night: got %h want %h", obs, expv()); bad++;
    end
    night = 1'b0;
    rst = 1'b0;
    @(negedge Fin);
    total++;
    if (obs !== expv()) begin
      $display("FAIL reset_night_release: got %h want %h", obs, expv()); bad++;
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        do_tick();
      end else if (r < 8) begin
        night = ~night;
        if (night) m_night_on();
        else m_night_off();
        @(negedge Fin);
      end else begin
`ifdef PED_REQ_EN
        if (r == 9) req_pulse();
`endif
        repeat ($urandom_range(1, 20)) @(negedge Fin);
      end
      total++;
      if (obs !== expv()) begin
        $display("FAIL random[%0d]: got %h want %h", i, obs, expv()); bad++;
      end
    end
    night = 1'b0;
    m_night_off();
    @(negedge Fin);
  endtask

`ifdef PED_REQ_EN
  task automatic test_ped();
    rst = 1'b1;
    m_reset();
    @(negedge Fin);
    rst = 1'b0;
    @(negedge Fin);
    for (int i = 0; i < 22; i++) begin
      do_tick();
      total++;
      if (obs !== expv()) begin
        $display("FAIL ped_park[%0d]: got %h want %h", i, obs, expv()); bad++;
      end
    end
    req_pulse();
    do_tick();
    total++;
    if (obs !== expv() || phase !== 3'd1) begin
      $display("FAIL ped_go: got %h want %h", obs, expv()); bad++;
    end
    go_to(0, 1, 1'b0);
    do_tick();
    total++;
    if (obs !== expv() || phase !== 3'd0) begin
      $display("FAIL ped_consumed: got %h want %h", obs, expv()); bad++;
    end
    req_pulse();
    go_to(2, 1, 1'b0);
    side_req = 1'b1;
    tick_rise();
    side_req = 1'b0;
    tick_fall();
    go_to(0, 1, 1'b0);
    do_tick();
    total++;
    if (obs !== expv() || phase !== 3'd0) begin
      $display("FAIL ped_clear_wins: got %h want %h", obs, expv()); bad++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cycle();
    test_hold();
    test_night();
    test_night_tick();
    test_reset_mid();
    test_random();
`ifdef PED_REQ_EN
    test_ped();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
